// File: rtl/p4_instr_sequencer_if.sv
// Host/CPU-facing bus of the instruction sequencer.
// The master side is the host plus CPU (program load, run control, CPU w flag);
// the slave side is the sequencer itself.
interface p4_instr_sequencer_if #(
  parameter int AW = 4
) ();
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          run;
  logic          abort;
  logic          cpu_w;
  logic          cpu_load;
  logic [15:0]   cpu_in;
  logic          cpu_s;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, run, abort, cpu_w,
    input  cpu_load, cpu_in, cpu_s, busy, done, err, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, run, abort, cpu_w,
    output cpu_load, cpu_in, cpu_s, busy, done, err, pc
  );
endinterface

// File: rtl/p4_instr_sequencer.sv
// Program buffer and issue controller for the Simple RISC Machine CPU.
// Host fills the buffer, pulses run; instructions are issued in order through
// load/in/s, paced by the CPU w flag, with timeout and abort handling.
module p4_instr_sequencer #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset,
  p4_instr_sequencer_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   LEN_ONE  = 1;
  localparam logic [AW-1:0] PC_ONE   = 1;
  localparam logic [TW-1:0] TMO_ONE  = 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW:0]   r_len;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_cpu_in;
  logic          r_done;
  logic          r_err;

  logic          w_last;
  logic          w_tmo_hit;
  logic          w_issue;
  logic          w_latch_len;
  logic          w_tmo_clr;
  logic          w_done_nxt;
  logic          w_err_set;
  logic          w_err_clr;

  // The last instruction is the one at index len-1 (len is never 0 while busy).
  assign w_last    = ({1'b0, r_pc} == (r_len - LEN_ONE));
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  // Next-state and control decode; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_issue     = 1'b0;
    w_latch_len = 1'b0;
    w_tmo_clr   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          if (bus.prog_len == '0) begin
            w_done_nxt = 1'b1;
          end else if (bus.cpu_w) begin
            w_state_nxt = S_LOAD;
            w_pc_nxt    = '0;
            w_latch_len = 1'b1;
            w_err_clr   = 1'b1;
            w_issue     = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_state_nxt = S_START;
        w_tmo_clr   = 1'b1;
      end
      S_START: begin
        if (!bus.cpu_w) begin
          w_state_nxt = S_EXEC;
          w_tmo_clr   = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
        end
      end
      S_EXEC: begin
        if (bus.cpu_w) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_LOAD;
            w_pc_nxt    = r_pc + PC_ONE;
            w_issue     = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (bus.abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_pc_nxt    = r_pc;
      w_issue     = 1'b0;
      w_latch_len = 1'b0;
      w_tmo_clr   = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Program pointer, latched length, timeout counter, issued word and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= '0;
      r_len    <= '0;
      r_tmo    <= '0;
      r_cpu_in <= 16'h0000;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_done <= w_done_nxt;
      if (w_latch_len) begin
        r_len <= bus.prog_len;
      end
      if (w_tmo_clr) begin
        r_tmo <= '0;
      end else if ((r_state == S_START) || (r_state == S_EXEC)) begin
        r_tmo <= r_tmo + TMO_ONE;
      end
      if (w_issue) begin
        r_cpu_in <= r_mem[w_pc_nxt];
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Program buffer write port; only the idle host may change the program.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (r_state == S_IDLE)) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign bus.cpu_load = (r_state == S_LOAD);
  assign bus.cpu_s    = (r_state == S_START);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.cpu_in   = r_cpu_in;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.pc       = r_pc;

endmodule

// File: tb/tb_p4_instr_sequencer.sv
// Scoreboard bench for p4_instr_sequencer: stimulus pushes expected load/done/err
// events, an independent monitor pops and compares them as the DUT produces them.
module tb_p4_instr_sequencer;
  localparam int AW      = 4;
  localparam int TIMEOUT = 64;

  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [15:0]   data;
    logic [AW-1:0] pc;
  } evt_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  p4_instr_sequencer_if #(.AW(AW)) bus ();

  p4_instr_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  evt_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cpu_mode = 0;   // 0: normal CPU, 1: hung (w stays 1), 2: w driven by stimulus
  int   exec_cyc = 4;
  logic model_w  = 1'b1;
  logic man_w    = 1'b1;
  logic err_q    = 1'b0;

  assign bus.cpu_w = (cpu_mode == 2) ? man_w : model_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_evt(input logic [1:0] k, input logic [15:0] d, input logic [AW-1:0] p);
    evt_t e;
    e.kind = k;
    e.data = d;
    e.pc   = p;
    sbq.push_back(e);
  endtask

  task automatic observe(input logic [1:0] k, input logic [15:0] d, input logic [AW-1:0] p);
    evt_t e;
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind=%0d data=%h pc=%0d expected no event", k, d, p);
    end else begin
      e = sbq.pop_front();
      if ((e.kind !== k) || ((k == K_LOAD) && ((e.data !== d) || (e.pc !== p)))) begin
        n_fail++;
        $display("FAIL sb_event: got kind=%0d data=%h pc=%0d expected kind=%0d data=%h pc=%0d",
                 k, d, p, e.kind, e.data, e.pc);
      end
    end
  endtask

  // Monitor: every load pulse, done pulse and err rising edge is one event.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.cpu_load) observe(K_LOAD, bus.cpu_in, bus.pc);
      if (bus.done) observe(K_DONE, 16'h0000, bus.pc);
      if (bus.err && !err_q) observe(K_ERR, 16'h0000, bus.pc);
      if (bus.done && bus.err) check("done_err_exclusive", 32'd1, 32'd0);
    end
    err_q = bus.err;
  end

  // CPU model: after seeing s, drop w for exec_cyc cycles then return to wait.
  initial begin
    forever begin
      @(negedge clk);
      if ((cpu_mode == 0) && bus.cpu_s && model_w) begin
        model_w = 1'b0;
        repeat (exec_cyc) @(negedge clk);
        model_w = 1'b1;
      end
    end
  end

  task automatic prog_write(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  // Returns #1 after the accepting edge (LOAD cycle).
  task automatic start_run(input logic [AW:0] len);
    @(negedge clk);
    bus.prog_len = len;
    bus.run      = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) break;
    end
    check("run_accepted", bus.busy, 1);
    bus.run = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; (i < 2000) && bus.busy; i++) @(negedge clk);
    check(name, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [15:0] w;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.prog_len  = '0;
    bus.run       = 1'b0;
    bus.abort     = 1'b0;

    // Reset state
    #12;
    check("rst_cpu_load", bus.cpu_load, 0);
    check("rst_cpu_s", bus.cpu_s, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_pc", bus.pc, 0);
    check("rst_cpu_in", bus.cpu_in, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    prog_write(4'd0, 16'hC212);
    prog_write(4'd1, 16'hE30A);
    prog_write(4'd2, 16'hA4A5);

    // Reset mid-run while in START
    cpu_mode = 1;
    push_evt(K_LOAD, 16'hC212, 4'd0);
    start_run(5'd3);
    for (int i = 0; (i < 10) && !bus.cpu_s; i++) @(negedge clk);
    check("midrst_in_start", bus.cpu_s, 1);
    #1 reset = 1'b0;
    #1;
    check("midrst_cpu_s", bus.cpu_s, 0);
    check("midrst_cpu_load", bus.cpu_load, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_pc", bus.pc, 0);
    @(negedge clk);
    reset    = 1'b1;
    cpu_mode = 0;

    // Three-instruction program with latency checks
    push_evt(K_LOAD, 16'hC212, 4'd0);
    push_evt(K_LOAD, 16'hE30A, 4'd1);
    push_evt(K_LOAD, 16'hA4A5, 4'd2);
    push_evt(K_DONE, 16'h0000, 4'd0);
    start_run(5'd3);
    check("lat_cycle1_load", bus.cpu_load, 1);
    check("lat_cycle1_err", bus.err, 0);
    @(posedge clk);
    #1;
    check("lat_cycle2_s", bus.cpu_s, 1);
    check("lat_cycle2_load", bus.cpu_load, 0);
    wait_idle("three_idle");
    check("three_pc", bus.pc, 2);
    check("three_err", bus.err, 0);

    // Zero-length run: done pulse, never busy
    push_evt(K_DONE, 16'h0000, 4'd0);
    @(negedge clk);
    bus.prog_len = 5'd0;
    bus.run      = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    check("zero_busy", bus.busy, 0);
    check("zero_done", bus.done, 1);
    repeat (3) @(negedge clk);
    check("zero_busy_after", bus.busy, 0);

    // Hold-off while CPU not waiting
    cpu_mode = 2;
    man_w    = 1'b0;
    push_evt(K_LOAD, 16'hC212, 4'd0);
    push_evt(K_DONE, 16'h0000, 4'd0);
    @(negedge clk);
    bus.prog_len = 5'd1;
    bus.run      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("holdoff_no_load", bus.cpu_load, 0);
      check("holdoff_no_busy", bus.busy, 0);
    end
    man_w = 1'b1;
    @(posedge clk);
    #1;
    check("holdoff_load_next", bus.cpu_load, 1);
    bus.run  = 1'b0;
    cpu_mode = 0;
    wait_idle("holdoff_idle");

    // Timeout in START
    cpu_mode = 1;
    push_evt(K_LOAD, 16'hC212, 4'd0);
    push_evt(K_ERR, 16'h0000, 4'd0);
    start_run(5'd1);
    for (int i = 0; (i < 10) && !bus.cpu_s; i++) @(negedge clk);
    cnt = 0;
    while (bus.cpu_s && (cnt < 200)) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_cycles", cnt, TIMEOUT);
    check("tmo_err", bus.err, 1);
    check("tmo_busy", bus.busy, 0);
    check("tmo_done", bus.done, 0);
    cpu_mode = 0;

    // Next accepted run clears err
    push_evt(K_LOAD, 16'hC212, 4'd0);
    push_evt(K_DONE, 16'h0000, 4'd0);
    start_run(5'd1);
    check("err_cleared", bus.err, 0);
    wait_idle("errclr_idle");

    // Abort in EXEC at pc=1, with a buffer write attempted while busy
    push_evt(K_LOAD, 16'hC212, 4'd0);
    push_evt(K_LOAD, 16'hE30A, 4'd1);
    start_run(5'd3);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = 16'hDEAD;
    @(negedge clk);
    bus.prog_we   = 1'b0;
    for (int i = 0; (i < 100) &&
         !(bus.busy && !bus.cpu_load && !bus.cpu_s && (bus.pc == 4'd1)); i++) @(negedge clk);
    check("abort_in_exec_pc1", bus.pc, 1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_cpu_s", bus.cpu_s, 0);
    check("abort_cpu_load", bus.cpu_load, 0);
    check("abort_pc", bus.pc, 1);
    repeat (3) @(negedge clk);

    // Buffer word 0 must be unchanged by the busy-time write
    push_evt(K_LOAD, 16'hC212, 4'd0);
    push_evt(K_DONE, 16'h0000, 4'd0);
    start_run(5'd1);
    wait_idle("verify_idle");

    // Full buffer
    for (int i = 0; i < 16; i++) begin
      w = 16'h1000 + 16'(i) * 16'h0111;
      prog_write(4'(i), w);
      push_evt(K_LOAD, w, 4'(i));
    end
    push_evt(K_DONE, 16'h0000, 4'd0);
    start_run(5'd16);
    wait_idle("full_idle");
    check("full_pc", bus.pc, 15);
    check("full_err", bus.err, 0);

    repeat (2) @(negedge clk);
    check("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/p4_instr_sequencer.md
Name: p4_instr_sequencer

Overview:
- Program buffer and issue controller upstream of the Simple RISC Machine CPU.
- Host software writes a short instruction sequence into an internal buffer, then pulses run.
- The block issues each instruction in order through the CPU's load/in/s interface and paces itself on the CPU's w (waiting) flag.
- Reports busy/done/error status so the bench or top level can run multi-instruction programs without hand-timed stimulus.

Parameters:
- AW, 4, address width of the program buffer; depth = 2**AW entries.
- TIMEOUT, 64, maximum cycles to wait for w in START or EXEC before flagging an error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- prog_we  input  1  write strobe into the program buffer.
- prog_addr  input  AW  buffer write address.
- prog_data  input  16  instruction word to store.
- prog_len  input  AW+1  number of instructions to run, 0..2**AW; sampled when run is accepted.
- run  input  1  start request; level-sensitive, acted on only in IDLE.
- abort  input  1  synchronous abort of the current program.
- cpu_w  input  1  CPU w output; 1 = CPU is in its wait state.
- cpu_load  output  1  drives the CPU load input (instruction register enable).
- cpu_in  output  16  drives the CPU in bus.
- cpu_s  output  1  drives the CPU s (start) input.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last instruction completes.
- err  output  1  sticky timeout flag; cleared by reset or by the next accepted run.
- pc  output  AW  index of the instruction currently issued.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; cpu_load, cpu_s, busy, done, err = 0; cpu_in = 16'h0000; pc = 0; latched length = 0; timeout counter = 0. Buffer contents are not reset.
- Buffer writes: synchronous, 1 port, accepted only in IDLE. prog_we outside IDLE is ignored (no write).
- IDLE -> LOAD: requires run=1, prog_len!=0 and cpu_w=1. On that edge: latch prog_len, pc=0, err=0.
  - run with prog_len=0: no state change, done pulses for 1 cycle.
  - run while cpu_w=0: held off, no action.
- LOAD (1 cycle): cpu_load=1; cpu_in=mem[pc]. Next state is START.
- START: cpu_s=1; cpu_in holds mem[pc].
  - Stay in START while cpu_w=1.
  - On the first cycle cpu_w=0, go to EXEC; cpu_s=0 from then on.
- EXEC: cpu_s=0; wait for cpu_w=1.
  - If pc==len-1: go to IDLE and pulse done.
  - Otherwise: pc=pc+1 and go to LOAD.
- Timeout: a counter clears on entry to START and on entry to EXEC. If it reaches TIMEOUT while in START or EXEC: err=1, go to IDLE, cpu_s=0, no done pulse.
- abort=1 in any non-IDLE state: on the next edge go to IDLE with cpu_load=0 and cpu_s=0. pc and err hold their values; no done pulse. abort has priority over every other transition. abort in IDLE has no effect.
- cpu_in holds its last driven value outside LOAD/START; it changes only on entry to LOAD.
- Latency, from the edge that accepts run (cycle 0):
  - cpu_load high in cycle 1.
  - cpu_s high from cycle 2.
  - Minimum per-instruction issue period = 3 cycles plus CPU execution time.
- pc arithmetic is unsigned AW-bit. Since len ≤ 2**AW, pc never wraps during a run.
- Outputs are registered (Moore): cpu_load, cpu_s and busy are decoded from the state register, with no combinational path from cpu_w.
- done and err are mutually exclusive in any given cycle.

Test Plan:
- Reset mid-run: assert reset=0 during START -> cpu_s, cpu_load, busy drop asynchronously at once; pc=0, state IDLE. After reset=1, run proceeds normally.
- Three-instruction program: write 16'hC212, 16'hE30A, 16'hA4A5 at addresses 0..2, prog_len=3, run=1, CPU model with cpu_w low 4 cycles per instruction -> three cpu_load pulses carrying those words in order, each followed by cpu_s held until cpu_w falls. pc steps 0,1,2; a single done pulse; err=0.
- Edge cases: prog_len=0 with run -> done pulse, busy never rises. prog_len=16 (full buffer) -> all 16 words issued, pc ends at 15, no wrap.
- Timeout: CPU model holds cpu_w=1 forever after s -> err=1 after exactly TIMEOUT cycles in START, return to IDLE, no done. A following run clears err.
- Abort during EXEC at pc=1 -> next cycle IDLE, cpu_s=0, pc stays 1, no done. prog_we issued while busy leaves the buffer unchanged (verified by a later run).
- Handshake hold-off: run asserted while cpu_w=0 -> no cpu_load until cpu_w=1, then cpu_load the following cycle.
